axi4_video_stream_checker: RTL

- AXI4-Stream video sink/monitor placed directly downstream of the video pattern generator or any stage that produces the same stream format.
- Stream format: tuser marks start-of-frame (SOF); tlast marks end-of-line (EOL); tdata carries 3x10-bit components in bits 29:0.
- Locks to SOF, measures line length and lines per frame, compares both against the expected geometry and raises sticky error flags.
- Reports frame count, lock status and last-measured dimensions to software and debug.

---
 rtl/axi4_video_stream_checker_if.sv | 13 +
 rtl/axi4_video_stream_checker.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/axi4_video_stream_checker_if.sv
// AXI4-Stream video link: tdata[29:0] carries one pixel, tuser marks SOF, tlast marks EOL.
interface axi4_stream_if #(
    parameter int unsigned TDATA_WIDTH = 32
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic                   tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axi4_video_stream_checker.sv
// Video stream sink/monitor: locks to SOF, measures line length and lines per frame,
// and raises sticky geometry / reserved-bit error flags.
module axi4_video_stream_checker #(
    parameter int unsigned X_ACTIVE      = 1920,
    parameter int unsigned Y_ACTIVE      = 1080,
    parameter int unsigned TDATA_WIDTH   = 32,
    parameter int unsigned FRM_CNT_WIDTH = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    axi4_stream_if.slave                    video_i,
    input  logic                            clr_err_i,
    output logic                            locked_o,
    output logic                            frame_done_o,
    output logic [FRM_CNT_WIDTH-1:0]        frame_cnt_o,
    output logic [$clog2(X_ACTIVE+2)-1:0]   line_len_o,
    output logic [$clog2(Y_ACTIVE+2)-1:0]   frame_lines_o,
    output logic                            err_short_line_o,
    output logic                            err_long_line_o,
    output logic                            err_early_sof_o,
    output logic                            err_frame_lines_o,
    output logic                            err_rsvd_o
);
    localparam int unsigned PXW = $clog2(X_ACTIVE + 2);
    localparam int unsigned LNW = $clog2(Y_ACTIVE + 2);
    localparam logic [PXW-1:0] XMAX = PXW'(X_ACTIVE);
    localparam logic [PXW-1:0] XSAT = PXW'(X_ACTIVE + 1);
    localparam logic [LNW-1:0] YMAX = LNW'(Y_ACTIVE);

    typedef enum logic [1:0] {StWaitSof, StActive, StExpectSof} state_e;

    state_e                   state_q;
    logic                     tready_q;
    logic [PXW-1:0]           px_cnt_q;
    logic [LNW-1:0]           ln_cnt_q;
    logic                     long_seen_q;
    logic                     frame_err_q;
    logic                     locked_q;
    logic                     frame_done_q;
    logic [FRM_CNT_WIDTH-1:0] frame_cnt_q;
    logic [PXW-1:0]           line_len_q;
    logic [LNW-1:0]           frame_lines_q;
    logic                     err_short_q, err_long_q, err_early_q, err_lines_q, err_rsvd_q;

    logic           beat, sof, eol, in_line, early_sof;
    logic           short_set, long_set, lines_set, rsvd_set, any_set;
    logic [PXW-1:0] cnt_new;
    logic [LNW-1:0] ln_base, ln_new;
    logic           frame_end, frame_err_cur, clean_done;

    // Pixel payload is not inspected; only the reserved bits matter here.
    logic unused_pixel;
    assign unused_pixel = ^video_i.tdata[29:0];

    always_comb begin
        beat      = video_i.tvalid & tready_q;
        sof       = beat & video_i.tuser;
        eol       = beat & video_i.tlast;
        // Any tuser beat starts a line; otherwise beats only count while ACTIVE.
        in_line   = beat & (video_i.tuser | (state_q == StActive));
        early_sof = sof & (state_q == StActive);
        cnt_new   = sof ? PXW'(1) : ((px_cnt_q == XSAT) ? XSAT : px_cnt_q + PXW'(1));
        ln_base   = sof ? '0 : ln_cnt_q;
        ln_new    = ln_base + LNW'(1);
        short_set = in_line & eol & (cnt_new < XMAX);
        long_set  = in_line & ~eol & (cnt_new >= XMAX) & ~(long_seen_q & ~video_i.tuser);
        lines_set = (early_sof & (ln_cnt_q != '0))
                  | (beat & ~video_i.tuser & (state_q == StExpectSof));
        rsvd_set  = beat & (|video_i.tdata[TDATA_WIDTH-1:30]);
        any_set   = short_set | long_set | early_sof | lines_set | rsvd_set;
        frame_end = in_line & eol & (ln_new == YMAX);
        // An early SOF's own error belongs to the truncated frame, not the one it opens.
        frame_err_cur = sof ? (short_set | long_set | rsvd_set) : (frame_err_q | any_set);
        clean_done    = frame_end & ~frame_err_cur;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= StWaitSof;
            tready_q      <= 1'b0;
            px_cnt_q      <= '0;
            ln_cnt_q      <= '0;
            long_seen_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            locked_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_early_q   <= 1'b0;
            err_lines_q   <= 1'b0;
            err_rsvd_q    <= 1'b0;
        end else begin
            tready_q     <= 1'b1;
            frame_done_q <= clean_done;
            if (clean_done) frame_cnt_q <= frame_cnt_q + FRM_CNT_WIDTH'(1);

            if (any_set)         locked_q <= 1'b0;
            else if (clean_done) locked_q <= 1'b1;

            err_short_q <= (err_short_q & ~clr_err_i) | short_set;
            err_long_q  <= (err_long_q  & ~clr_err_i) | long_set;
            err_early_q <= (err_early_q & ~clr_err_i) | early_sof;
            err_lines_q <= (err_lines_q & ~clr_err_i) | lines_set;
            err_rsvd_q  <= (err_rsvd_q  & ~clr_err_i) | rsvd_set;

            if (in_line) begin
                frame_err_q <= frame_err_cur;
                if (eol) begin
                    line_len_q  <= cnt_new;
                    px_cnt_q    <= '0;
                    ln_cnt_q    <= ln_new;
                    long_seen_q <= 1'b0;
                end else begin
                    px_cnt_q    <= cnt_new;
                    ln_cnt_q    <= ln_base;
                    long_seen_q <= (long_seen_q & ~video_i.tuser) | long_set;
                end
            end

            if (frame_end)      frame_lines_q <= YMAX;
            else if (early_sof) frame_lines_q <= ln_cnt_q;

            if (frame_end)                             state_q <= StExpectSof;
            else if (sof)                              state_q <= StActive;
            else if (beat && state_q == StExpectSof)   state_q <= StWaitSof;
        end
    end

    assign video_i.tready    = tready_q;
    assign locked_o          = locked_q;
    assign frame_done_o      = frame_done_q;
    assign frame_cnt_o       = frame_cnt_q;
    assign line_len_o        = line_len_q;
    assign frame_lines_o     = frame_lines_q;
    assign err_short_line_o  = err_short_q;
    assign err_long_line_o   = err_long_q;
    assign err_early_sof_o   = err_early_q;
    assign err_frame_lines_o = err_lines_q;
    assign err_rsvd_o        = err_rsvd_q;
endmodule
